jtdsp16_paau: RTL and testbench

JTDSP16_PAAU -- requirements
Module: jtdsp16_paau

---
 rtl/jtdsp16_paau.sv | 153 +++++++++++++++
 tb/tb_jtdsp16_paau.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_paau.sv
// Pointer arithmetic / address unit: NPTR pointers plus j, k, rb, re and a mode
// register. It supports linear, circular (rb..re) and bit-reversed post-modify.
// Ports: reg_sel/load strobes write one register; reg_dout reads it.
//        ptr_sel picks the pointer that drives ram_addr and is post-modified.
//        wrap flags a circular wrap on the last enabled edge; mode is the mode register.
module jtdsp16_paau #(
  parameter int DW   = 16,
  parameter int AW   = 11,
  parameter int NPTR = 4,
  parameter int SW   = 9,
  localparam int PW  = $clog2(NPTR),
  localparam int RW  = PW + 1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic [RW-1:0] reg_sel,
  input  logic [PW-1:0] ptr_sel,
  input  logic [1:0]    inc_sel,
  input  logic          step_sel,
  input  logic          ksel,
  input  logic          short_load,
  input  logic          long_load,
  input  logic          acc_load,
  input  logic          ram_load,
  input  logic          post_load,
  input  logic          mode_load,
  input  logic [1:0]    mode_in,
  input  logic [SW-1:0] short_imm,
  input  logic [DW-1:0] long_imm,
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] ram_dout,
  output logic [DW-1:0] reg_dout,
  output logic [AW-1:0] ram_addr,
  output logic          wrap,
  output logic [1:0]    mode
);

  logic [DW-1:0] ptr [NPTR];
  logic [DW-1:0] j_reg, k_reg, rb, re;

  // reg_sel is widened so codes beyond the encodable range (NPTR=2) never alias a pointer
  logic [31:0] sel_w;
  logic        sel_ptr, sel_j, sel_k, sel_rb, sel_re;
  assign sel_w   = 32'(reg_sel);
  assign sel_ptr = sel_w < 32'(NPTR);
  assign sel_j   = sel_w == 32'(NPTR);
  assign sel_k   = sel_w == 32'(NPTR + 1);
  assign sel_rb  = sel_w == 32'(NPTR + 2);
  assign sel_re  = sel_w == 32'(NPTR + 3);

  logic any_load;
  assign any_load = short_load | long_load | acc_load | ram_load;

  // Load data: long immediate > short immediate > acc > ram_dout.
  // Short immediates are signed only when they target the step registers j/k.
  logic [DW-1:0] load_dat;
  always_comb begin
    load_dat = ram_dout;
    if (long_load)
      load_dat = long_imm;
    else if (short_load)
      load_dat = (sel_j || sel_k) ? DW'($signed(short_imm)) : DW'(short_imm);
    else if (acc_load)
      load_dat = acc;
  end

  logic [DW-1:0] unit, step;
  always_comb begin
    case (inc_sel)
      2'd0:    unit = '1;
      2'd1:    unit = '0;
      2'd2:    unit = DW'(1);
      default: unit = DW'(2);
    endcase
    step = step_sel ? (ksel ? k_reg : j_reg) : unit;
  end

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = x[AW-1-i];
    return r;
  endfunction

  logic [DW-1:0] cur, nxt;
  logic [AW-1:0] br_low;
  logic          circ_wrap;
  assign cur    = ptr[ptr_sel];
  // Reverse-carry add: the carry propagates from the MSB toward the LSB of the address field
  assign br_low = bitrev(bitrev(cur[AW-1:0]) + bitrev(step[AW-1:0]));

  always_comb begin
    nxt       = cur + step;
    circ_wrap = 1'b0;
    case (mode)
      2'd1: begin
        // re==0 disables the circular buffer so the pointer moves linearly
        if (re != '0) begin
          if (!step[DW-1] && cur == re) begin
            nxt       = rb;
            circ_wrap = 1'b1;
          end else if (step[DW-1] && cur == rb) begin
            nxt       = re;
            circ_wrap = 1'b1;
          end
        end
      end
      2'd2: begin
        nxt         = cur;
        nxt[AW-1:0] = br_low;
      end
      default: ;
    endcase
  end

  // A load of the post-modified pointer overrides the post-modify and its wrap
  logic same_ptr, do_post;
  assign same_ptr = any_load && sel_ptr && (reg_sel[PW-1:0] == ptr_sel);
  assign do_post  = post_load && !same_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPTR; i++) ptr[i] <= '0;
      j_reg <= '0;
      k_reg <= '0;
      rb    <= '0;
      re    <= '0;
      mode  <= 2'd0;
      wrap  <= 1'b0;
    end else if (cen) begin
      if (do_post) ptr[ptr_sel] <= nxt;
      if (any_load && sel_ptr) ptr[reg_sel[PW-1:0]] <= load_dat;
      if (any_load && sel_j)  j_reg <= load_dat;
      if (any_load && sel_k)  k_reg <= load_dat;
      if (any_load && sel_rb) rb    <= load_dat;
      if (any_load && sel_re) re    <= load_dat;
      if (mode_load) mode <= mode_in;
      wrap <= do_post && circ_wrap;
    end
  end

  always_comb begin
    reg_dout = '0;
    if (sel_ptr)     reg_dout = ptr[reg_sel[PW-1:0]];
    else if (sel_j)  reg_dout = j_reg;
    else if (sel_k)  reg_dout = k_reg;
    else if (sel_rb) reg_dout = rb;
    else if (sel_re) reg_dout = re;
  end

  assign ram_addr = cur[AW-1:0];

endmodule

// File: tb/tb_jtdsp16_paau.sv
// Directed bench for jtdsp16_paau: a default instance and an AW=3 instance share stimulus.
// Inputs change 1ns after the rising edge and outputs are sampled there as well.
module tb_jtdsp16_paau;
  logic        clk = 1'b0;
  logic        rst, cen;
  logic [2:0]  reg_sel;
  logic [1:0]  ptr_sel, inc_sel, mode_in;
  logic        step_sel, ksel, short_load, long_load, acc_load, ram_load, post_load, mode_load;
  logic [8:0]  short_imm;
  logic [15:0] long_imm, acc, ram_dout;
  logic [15:0] reg_dout, reg_dout_b;
  logic [10:0] ram_addr;
  logic [2:0]  ram_addr_b;
  logic        wrap, wrap_b;
  logic [1:0]  mode, mode_b;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  jtdsp16_paau dut (
    .rst(rst), .clk(clk), .cen(cen), .reg_sel(reg_sel), .ptr_sel(ptr_sel), .inc_sel(inc_sel),
    .step_sel(step_sel), .ksel(ksel), .short_load(short_load), .long_load(long_load),
    .acc_load(acc_load), .ram_load(ram_load), .post_load(post_load), .mode_load(mode_load),
    .mode_in(mode_in), .short_imm(short_imm), .long_imm(long_imm), .acc(acc), .ram_dout(ram_dout),
    .reg_dout(reg_dout), .ram_addr(ram_addr), .wrap(wrap), .mode(mode)
  );

  jtdsp16_paau #(.AW(3)) dut_b (
    .rst(rst), .clk(clk), .cen(cen), .reg_sel(reg_sel), .ptr_sel(ptr_sel), .inc_sel(inc_sel),
    .step_sel(step_sel), .ksel(ksel), .short_load(short_load), .long_load(long_load),
    .acc_load(acc_load), .ram_load(ram_load), .post_load(post_load), .mode_load(mode_load),
    .mode_in(mode_in), .short_imm(short_imm), .long_imm(long_imm), .acc(acc), .ram_dout(ram_dout),
    .reg_dout(reg_dout_b), .ram_addr(ram_addr_b), .wrap(wrap_b), .mode(mode_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    short_load = 0; long_load = 0; acc_load = 0; ram_load = 0;
    post_load = 0; mode_load = 0; step_sel = 0; ksel = 0;
  endtask

  task automatic ld_long(input logic [2:0] sel, input logic [15:0] d);
    idle(); reg_sel = sel; long_imm = d; long_load = 1; tick(); long_load = 0;
  endtask

  task automatic ld_short(input logic [2:0] sel, input logic [8:0] d);
    idle(); reg_sel = sel; short_imm = d; short_load = 1; tick(); short_load = 0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    idle(); mode_in = m; mode_load = 1; tick(); mode_load = 0;
  endtask

  task automatic post(input logic [1:0] p, input logic [1:0] inc);
    idle(); ptr_sel = p; inc_sel = inc; post_load = 1; tick(); post_load = 0;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] sel, input logic [15:0] exp);
    reg_sel = sel; #1;
    check(tag, reg_dout, exp);
  endtask

  logic [15:0] circ_exp [3] = '{16'h11, 16'h12, 16'h10};
  logic [15:0] br_exp   [4] = '{16'h4, 16'h2, 16'h6, 16'h1};

  initial begin
    rst = 1; cen = 1; reg_sel = 0; ptr_sel = 0; inc_sel = 0; mode_in = 0;
    short_imm = 0; long_imm = 0; acc = 0; ram_dout = 0;
    idle();
    #3;
    check("rst_mode", mode, 0);
    check("rst_wrap", wrap, 0);
    check("rst_addr", ram_addr, 0);
    for (int i = 0; i < 8; i++) chk_reg("rst_reg", 3'(i), 16'h0);
    @(posedge clk); #1; rst = 0;

    // Long load and address output
    ld_long(1, 16'h0123);
    chk_reg("p1_long", 1, 16'h0123);
    ptr_sel = 1; #1;
    check("addr_p1", ram_addr, 11'h123);

    // Short immediate extension
    ld_short(4, 9'h1FF); chk_reg("j_sext", 4, 16'hFFFF);
    ld_short(0, 9'h1FF); chk_reg("p0_zext", 0, 16'h01FF);
    ld_short(5, 9'h0FF); chk_reg("k_pos", 5, 16'h00FF);

    // Load source priority
    short_imm = 9'h011; long_imm = 16'h2222; acc = 16'h3333; ram_dout = 16'h4444;
    for (int c = 0; c < 4; c++) begin
      idle(); reg_sel = 3;
      long_load = (c == 0); short_load = (c <= 1); acc_load = (c <= 2); ram_load = 1;
      tick(); idle();
      case (c)
        0: chk_reg("prio_long", 3, 16'h2222);
        1: chk_reg("prio_short", 3, 16'h0011);
        2: chk_reg("prio_acc", 3, 16'h3333);
        default: chk_reg("prio_ram", 3, 16'h4444);
      endcase
    end

    // Circular buffer 0x10..0x12
    set_mode(1);
    check("mode_circ", mode, 1);
    ld_long(6, 16'h10); ld_long(7, 16'h12); ld_long(0, 16'h10);
    for (int i = 0; i < 3; i++) begin
      post(0, 2);
      check("circ_wrap", wrap, (i == 2) ? 1 : 0);
      chk_reg("circ_p0", 0, circ_exp[i]);
    end
    post(0, 0);
    check("circ_dn_wrap", wrap, 1);
    chk_reg("circ_dn_p0", 0, 16'h12);

    // cen low: strobes ignored, wrap held
    idle(); cen = 0; ptr_sel = 0; inc_sel = 2; post_load = 1;
    reg_sel = 1; long_imm = 16'hAAAA; long_load = 1; mode_in = 3; mode_load = 1;
    repeat (3) tick();
    check("hold_wrap", wrap, 1);
    check("hold_mode", mode, 1);
    check("hold_p1", reg_dout, 16'h0123);
    chk_reg("hold_p0", 0, 16'h12);
    idle(); cen = 1;

    // re load in the same cycle as post-modify uses the old re
    reg_sel = 7; long_imm = 16'h20; long_load = 1; ptr_sel = 0; inc_sel = 2; post_load = 1;
    tick(); idle();
    check("old_re_wrap", wrap, 1);
    chk_reg("old_re_p0", 0, 16'h10);
    chk_reg("new_re", 7, 16'h20);

    // re==0 falls back to linear
    ld_long(7, 16'h0);
    post(0, 0);
    check("re0_wrap", wrap, 0);
    chk_reg("re0_p0", 0, 16'h0F);

    // Load beats post-modify on the same pointer, including its wrap
    ld_long(7, 16'h12); ld_long(0, 16'h12);
    idle(); reg_sel = 0; acc = 16'h55; acc_load = 1; ptr_sel = 0; inc_sel = 2; post_load = 1;
    tick(); idle();
    check("same_wrap", wrap, 0);
    chk_reg("same_p0", 0, 16'h55);

    // Different pointers both update
    idle(); reg_sel = 3; acc = 16'h77; acc_load = 1; ptr_sel = 0; inc_sel = 2; post_load = 1;
    tick(); idle();
    chk_reg("diff_p3", 3, 16'h77);
    chk_reg("diff_p0", 0, 16'h56);

    // Linear modulo wrap-around
    set_mode(0);
    ld_long(2, 16'h0);
    post(2, 0);
    chk_reg("lin_m1", 2, 16'hFFFF);
    ptr_sel = 2; #1;
    check("lin_addr", ram_addr, 11'h7FF);
    post(2, 3);
    chk_reg("lin_p2", 2, 16'h0001);

    // Mode 3 acts as linear even at re
    set_mode(3);
    ld_long(2, 16'h12);
    post(2, 2);
    check("m3_wrap", wrap, 0);
    chk_reg("m3_p2", 2, 16'h13);

    // Bit-reversed with j=4
    set_mode(2);
    ld_short(4, 9'h004);
    ld_long(0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      idle(); ptr_sel = 0; step_sel = 1; ksel = 0; post_load = 1;
      tick(); idle();
      chk_reg("br_p0", 0, br_exp[i]);
      check("br_p0_aw3", reg_dout_b, br_exp[i]);
    end
    ld_long(0, 16'hF800);
    idle(); ptr_sel = 0; step_sel = 1; post_load = 1; tick(); idle();
    chk_reg("br_hi", 0, 16'hF804);
    check("br_hi_aw3", reg_dout_b, 16'hF804);

    // Reset in the middle of a circular sequence
    set_mode(1);
    ld_long(6, 16'h10); ld_long(7, 16'h12); ld_long(0, 16'h11);
    post(0, 2); post(0, 2);
    check("pre_rst_wrap", wrap, 1);
    idle(); ptr_sel = 0; inc_sel = 2; post_load = 1;
    #1; rst = 1; #1;
    check("mid_rst_wrap", wrap, 0);
    check("mid_rst_mode", mode, 0);
    check("mid_rst_addr", ram_addr, 0);
    chk_reg("mid_rst_p0", 0, 16'h0);
    chk_reg("mid_rst_rb", 6, 16'h0);
    chk_reg("mid_rst_re", 7, 16'h0);
    chk_reg("mid_rst_j", 4, 16'h0);
    idle();
    @(posedge clk); #1; rst = 0;
    ld_long(1, 16'h0005);
    chk_reg("post_rst_p1", 1, 16'h0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
